// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data memory between the core's
// load/store port (priority) and a host preload/readback port.
// Host accesses use idle memory cycles; a starvation counter forces a host
// slot after MAX_WAIT refused cycles. Every host grant is followed by one
// HACK cycle that returns the ack and the registered read data.
// Optional build macro: DMEM_ARB_STATS_EN adds stat_cpu_stalls and
// stat_host_forced saturating counters.
module dmem_arbiter #(
    parameter int ADDR_W   = 6,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_ack,
    output logic [DATA_W-1:0] host_rdata,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_write_data,
    input  logic [DATA_W-1:0] mem_read_data
`ifdef DMEM_ARB_STATS_EN
    ,
    output logic [15:0]       stat_cpu_stalls,
    output logic [15:0]       stat_host_forced
`endif
);

    typedef enum logic {
        ARB  = 1'b0,
        HACK = 1'b1
    } state_t;

    localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

    state_t     state;
    logic [3:0] wait_cnt;
    logic       host_granted;

    // Grant and memory mux: host wins an idle slot or a starved slot, CPU otherwise.
    always_comb begin
        // NOTE: every output gets a default before any branch, so no path
        // leaves a signal unassigned and no latch is inferred.
        host_granted   = 1'b0;
        mem_addr       = cpu_addr;
        mem_write_data = cpu_wdata;
        mem_write      = cpu_req & cpu_we;
        // The host is never granted while in reset or in the ack cycle.
        if (!rst && state == ARB && host_req &&
            (!cpu_req || wait_cnt == MAX_WAIT_C)) begin
            host_granted   = 1'b1;
            mem_addr       = host_addr;
            mem_write_data = host_wdata;
            mem_write      = host_we;
        end
    end

    assign cpu_stall = cpu_req & host_granted;
    assign cpu_rdata = mem_read_data;

    // Arbitration FSM: grant -> HACK (ack + captured read data) -> ARB.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: registered state uses non-blocking assignments only, so every
        // register samples the pre-edge values regardless of statement order.
        if (rst) begin
            state      <= ARB;
            host_ack   <= 1'b0;
            host_rdata <= '0;
            wait_cnt   <= 4'd0;
        end else begin
            case (state)
                ARB: begin
                    if (host_granted) begin
                        state      <= HACK;
                        host_ack   <= 1'b1;
                        host_rdata <= mem_read_data;
                        wait_cnt   <= 4'd0;
                    end else begin
                        host_ack <= 1'b0;
                        if (!host_req) begin
                            wait_cnt <= 4'd0;
                        end else if (wait_cnt != MAX_WAIT_C) begin
                            wait_cnt <= wait_cnt + 4'd1;
                        end
                    end
                end
                HACK: begin
                    // A request held through the ack is a new one; it starts
                    // counting from the next ARB cycle.
                    state    <= ARB;
                    host_ack <= 1'b0;
                    if (!host_req) begin
                        wait_cnt <= 4'd0;
                    end
                end
                default: begin
                    state    <= ARB;
                    host_ack <= 1'b0;
                end
            endcase
        end
    end

`ifdef DMEM_ARB_STATS_EN
    // Saturating event counters for stalled CPU cycles and forced host grants.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_cpu_stalls  <= 16'd0;
            stat_host_forced <= 16'd0;
        end else begin
            if (cpu_stall && stat_cpu_stalls != 16'hFFFF) begin
                stat_cpu_stalls <= stat_cpu_stalls + 16'd1;
            end
            if (host_granted && cpu_req && stat_host_forced != 16'hFFFF) begin
                stat_host_forced <= stat_host_forced + 16'd1;
            end
        end
    end
`endif

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter that shares the single-port data memory (`_data_mem`) between the ARM core's load/store port and a host port used by loaders, debuggers and benches for preload and readback. The CPU port has priority; host accesses fill idle memory cycles, and a starvation counter forces a host slot after a bounded wait. The arbiter sits between `ARM` and `_data_mem` and stalls the core whenever it lends the memory to the host.

## Interface
- `ADDR_W`, 6, word-address width (64-word data memory)
- `DATA_W`, 32, data width
- `MAX_WAIT`, 4, maximum consecutive cycles a pending host request is refused before it is forced through (1..15)

- `clk`  in  1  system clock, rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `cpu_req`  in  1  CPU memory access this cycle (load or store)
- `cpu_we`  in  1  CPU store
- `cpu_addr`  in  ADDR_W  CPU word address
- `cpu_wdata`  in  DATA_W  CPU store data
- `cpu_rdata`  out  DATA_W  CPU load data, combinational from `mem_read_data`
- `cpu_stall`  out  1  CPU access not performed this cycle; core holds PC and writeback
- `host_req`  in  1  host access request, level, held until `host_ack`
- `host_we`  in  1  host write
- `host_addr`  in  ADDR_W  host word address, stable while `host_req`
- `host_wdata`  in  DATA_W  host write data, stable while `host_req`
- `host_ack`  out  1  one-cycle completion pulse
- `host_rdata`  out  DATA_W  registered read data, valid while `host_ack`
- `mem_write`  out  1  memory write enable
- `mem_addr`  out  ADDR_W  memory address
- `mem_write_data`  out  DATA_W  memory write data
- `mem_read_data`  in  DATA_W  memory asynchronous read data

## Operation
- FSM states: `ARB` (normal arbitration) and `HACK` (host ack cycle).
- Grant (combinational, in `ARB`):
  - The host is granted if `host_req` and either `!cpu_req` or `wait_cnt == MAX_WAIT`.
  - Otherwise the CPU is granted if `cpu_req`.
  - If neither is granted, the memory idles: `mem_write = 0`, and address/data follow the CPU port.
- In `HACK`, `host_req` is ignored and the CPU is granted if `cpu_req`. This prevents one request being served twice.
- Memory mux: the granted port drives `mem_addr` and `mem_write_data`. `mem_write = granted_we`.
- `cpu_stall = cpu_req & host_granted`.
- `cpu_rdata = mem_read_data` at all times. It is only meaningful when `cpu_req & !cpu_stall`.
- Host grant: at the rising edge, the FSM goes to `HACK`, `host_ack <= 1`, and `host_rdata <= mem_read_data` (for both reads and writes). The write commits at that same edge.
- `HACK` always returns to `ARB` after one cycle, with `host_ack <= 0`.
- `wait_cnt` (4 bits):
  - Increments each `ARB` cycle in which `host_req` is high and the host is not granted.
  - Clears on host grant, or when `host_req` is low.
  - Saturates at `MAX_WAIT`.
- Reset (asynchronous, any time): state `ARB`, `host_ack = 0`, `host_rdata = 0`, `wait_cnt = 0`, stats counters = 0.
  - An in-flight host access loses its ack. A write already committed at an earlier edge stands.
- Outputs during reset: `cpu_stall = 0`, `mem_write` follows the CPU port combinationally. The core is itself held in reset.

## Timing
- CPU access: zero-latency and combinational, identical to a direct core-to-memory connection when uncontended.
- Host access: the grant cycle is cycle N; `host_ack` and `host_rdata` are valid in cycle N+1.
- Minimum host spacing: 2 cycles per access (grant, ack).
- The host may keep `host_req` high through the ack cycle with new address/data. That request is eligible from cycle N+2.
- Worst-case host latency under continuous `cpu_req`: `MAX_WAIT` refused cycles, then grant, then ack = `MAX_WAIT + 2` cycles from request to ack.
- Worst-case CPU stall: 1 cycle per host access. Two host grants are never adjacent, because `HACK` intervenes.

## Configuration
- `DMEM_ARB_STATS_EN` defined:
  - Adds outputs `stat_cpu_stalls` and `stat_host_forced` (16 bits each, saturating at 0xFFFF, cleared by `rst`).
  - `stat_cpu_stalls` counts cycles with `cpu_stall`.
  - `stat_host_forced` counts host grants taken with `cpu_req` high.
- `DMEM_ARB_STATS_EN` undefined: the counters and ports are absent, with no area cost and no change in functional behaviour.

## Test plan
- CPU only: `cpu_req=1`, `cpu_we=1`, addr 0x05, wdata 0xDEADBEEF; next cycle a read of addr 0x05 -> `cpu_rdata = 0xDEADBEEF`, `cpu_stall = 0` throughout.
- Host only: host write 0x12345678 to 0x3F, then host read of 0x3F -> each `host_ack` arrives exactly 1 cycle after grant; the read ack carries `host_rdata = 0x12345678`. The second request is granted 2 cycles after the first.
- Contention: `cpu_req` held high continuously, `host_req` raised at cycle 0 with `MAX_WAIT = 4` -> host refused for cycles 0–3, granted at cycle 4 with `cpu_stall = 1` only in cycle 4, `host_ack` in cycle 5.
- Held request: `host_req` kept high across the ack with a new address -> no double access in the `HACK` cycle; the second access is granted in the following cycle.
- Reset mid-op: assert `rst` in the `HACK` cycle -> `host_ack` and `host_rdata` drop to 0 immediately. After release the FSM is in `ARB` and `wait_cnt = 0`.
- With `DMEM_ARB_STATS_EN`: rerun the contention case three times -> `stat_cpu_stalls = 3`, `stat_host_forced = 3`.
